// File: rtl/mem_ctrl.sv
// CPU memory controller: routes word accesses to an internal RAM or to an external
// peripheral bus with an ack timeout, and keeps a sticky bus error flag.
module mem_ctrl #(
  parameter int RAM_WORDS   = 4096,
  parameter int PER_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_address,
  input  logic [31:0] cpu_write_data,
  input  logic        cpu_we,
  input  logic        cpu_re,
  output logic [31:0] cpu_read_data,
  output logic        cpu_mem_busy,
  output logic [31:0] per_address,
  output logic [31:0] per_write_data,
  output logic        per_we,
  output logic        per_re,
  input  logic [31:0] per_read_data,
  input  logic        per_ack,
  output logic        bus_error
);
  localparam int         AW      = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [7:0] TO_LAST = 8'(PER_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, RAM_ACC, PER_WAIT} state_t;

  state_t        r_state, w_state_next;
  logic [AW-1:0] r_idx, w_idx_next, w_req_idx;
  logic [31:0]   r_wdata, w_wdata_next;
  logic          r_write, w_write_next;
  logic          r_unmapped, w_unmapped_next;
  logic [7:0]    r_cnt, w_cnt_next;
  logic [31:0]   r_rdata, w_rdata_next;
  logic          r_busy, w_busy_next;
  logic [31:0]   r_per_addr, w_per_addr_next;
  logic [31:0]   r_per_wdata, w_per_wdata_next;
  logic          r_per_we, w_per_we_next;
  logic          r_per_re, w_per_re_next;
  logic          r_err, w_err_next;

  logic [31:0]   r_mem [RAM_WORDS];
  logic [31:0]   r_ram_q;

  logic w_req, w_is_ram, w_is_per, w_timeout;

  assign w_req     = cpu_re | cpu_we;
  assign w_is_ram  = (cpu_address[31:14] == 18'h00001);
  assign w_is_per  = (cpu_address[31:14] == 18'h00000);
  assign w_req_idx = AW'(32'(cpu_address[13:2]) % RAM_WORDS);
  assign w_timeout = (r_cnt == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_wdata     <= '0;
      r_write     <= 1'b0;
      r_unmapped  <= 1'b0;
      r_cnt       <= '0;
      r_rdata     <= '0;
      r_busy      <= 1'b0;
      r_per_addr  <= '0;
      r_per_wdata <= '0;
      r_per_we    <= 1'b0;
      r_per_re    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_idx       <= w_idx_next;
      r_wdata     <= w_wdata_next;
      r_write     <= w_write_next;
      r_unmapped  <= w_unmapped_next;
      r_cnt       <= w_cnt_next;
      r_rdata     <= w_rdata_next;
      r_busy      <= w_busy_next;
      r_per_addr  <= w_per_addr_next;
      r_per_wdata <= w_per_wdata_next;
      r_per_we    <= w_per_we_next;
      r_per_re    <= w_per_re_next;
      r_err       <= w_err_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:     if (w_req) w_state_next = w_is_per ? PER_WAIT : RAM_ACC;
      RAM_ACC:  w_state_next = IDLE;
      PER_WAIT: if (per_ack || w_timeout) w_state_next = IDLE;
      default:  w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_idx_next       = r_idx;
    w_wdata_next     = r_wdata;
    w_write_next     = r_write;
    w_unmapped_next  = r_unmapped;
    w_cnt_next       = r_cnt;
    w_rdata_next     = r_rdata;
    w_busy_next      = r_busy;
    w_per_addr_next  = r_per_addr;
    w_per_wdata_next = r_per_wdata;
    w_per_we_next    = r_per_we;
    w_per_re_next    = r_per_re;
    w_err_next       = r_err;
    case (r_state)
      IDLE: if (w_req) begin
        // A simultaneous re+we is executed as a write and flagged.
        w_idx_next      = w_req_idx;
        w_wdata_next    = cpu_write_data;
        w_write_next    = cpu_we;
        w_unmapped_next = !w_is_ram && !w_is_per;
        w_busy_next     = 1'b1;
        w_cnt_next      = '0;
        if (cpu_re && cpu_we) w_err_next = 1'b1;
        if (w_is_per) begin
          w_per_addr_next  = cpu_address;
          w_per_wdata_next = cpu_write_data;
          w_per_we_next    = cpu_we;
          w_per_re_next    = !cpu_we;
        end
      end
      RAM_ACC: begin
        w_busy_next = 1'b0;
        if (r_unmapped) begin
          w_err_next = 1'b1;
          if (!r_write) w_rdata_next = '0;
        end else if (!r_write) begin
          w_rdata_next = r_ram_q;
        end
      end
      PER_WAIT: begin
        if (per_ack || w_timeout) begin
          w_busy_next   = 1'b0;
          w_per_we_next = 1'b0;
          w_per_re_next = 1'b0;
          if (per_ack) begin
            if (!r_write) w_rdata_next = per_read_data;
          end else begin
            w_err_next = 1'b1;
            if (!r_write) w_rdata_next = 32'hFFFF_FFFF;
          end
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end
      default: ;
    endcase
    if (r_state != IDLE && w_req) w_err_next = 1'b1;
  end

  // RAM is read at the request edge so the word is ready when RAM_ACC exits.
  always_ff @(posedge clk) begin
    if (r_state == IDLE) r_ram_q <= r_mem[w_req_idx];
    if (r_state == RAM_ACC && r_write && !r_unmapped) r_mem[r_idx] <= r_wdata;
  end

  assign cpu_read_data  = r_rdata;
  assign cpu_mem_busy   = r_busy;
  assign per_address    = r_per_addr;
  assign per_write_data = r_per_wdata;
  assign per_we         = r_per_we;
  assign per_re         = r_per_re;
  assign bus_error      = r_err;
endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have one clock, clk; reset rst is asynchronous and active-high.
REQ-002 SHALL provide parameters (name, default, meaning):
- RAM_WORDS, 4096, depth of the internal 32-bit word RAM.
- PER_TIMEOUT, 255, maximum cycles to wait for per_ack (1..255).
REQ-003 SHALL provide ports (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  async active-high reset
- cpu_address  in  32  byte address from CPU
- cpu_write_data  in  32  store data
- cpu_we  in  1  one-cycle write request pulse
- cpu_re  in  1  one-cycle read request pulse
- cpu_read_data  out  32  read result
- cpu_mem_busy  out  1  transaction in progress
- per_address  out  32  peripheral address
- per_write_data  out  32  peripheral store data
- per_we  out  1  peripheral write strobe, level
- per_re  out  1  peripheral read strobe, level
- per_read_data  in  32  peripheral read result
- per_ack  in  1  peripheral completion, one cycle
- bus_error  out  1  sticky error flag

Function
REQ-004 SHALL decode addresses as follows:
- 0x0000_4000–0x0000_7FFF: RAM, word index cpu_address[13:2] modulo RAM_WORDS.
- 0x0000_0000–0x0000_3FFF: peripheral.
- All other addresses: unmapped.
REQ-005 SHALL ignore cpu_address[1:0] for all targets; the byte lane is resolved upstream.
REQ-006 SHALL implement FSM states IDLE, RAM_ACC, PER_WAIT.
REQ-007 In IDLE, on a clock edge sampling cpu_re=1 or cpu_we=1, SHALL latch address and write data, set cpu_mem_busy=1 and leave IDLE.
- RAM target goes to RAM_ACC.
- Peripheral target goes to PER_WAIT.
- Unmapped target goes to RAM_ACC with access suppressed.
REQ-008 If cpu_re and cpu_we are sampled together, SHALL treat the request as a write and set bus_error.
REQ-009 RAM_ACC SHALL last exactly one cycle. On its exit edge it SHALL:
- perform the write, or load cpu_read_data with mem[index];
- clear cpu_mem_busy;
- return to IDLE.
RAM read latency is therefore busy high for 1 cycle and data valid 2 edges after the request edge.
REQ-010 For an unmapped access, RAM_ACC SHALL leave RAM untouched, load cpu_read_data=0 on reads, and set bus_error.
REQ-011 On entry to PER_WAIT, SHALL drive the following at the same edge and hold them constant until exit:
- per_address = latched address;
- per_write_data = latched data;
- per_re or per_we.
REQ-012 In PER_WAIT, on an edge sampling per_ack=1, SHALL complete the transfer at that edge:
- reads load cpu_read_data=per_read_data;
- drop per_re/per_we;
- clear cpu_mem_busy;
- return to IDLE.
REQ-013 SHALL keep an 8-bit timeout counter, cleared on PER_WAIT entry. If PER_TIMEOUT edges pass without per_ack, SHALL abort:
- load cpu_read_data=32'hFFFF_FFFF on reads;
- drop the strobes and clear busy;
- set bus_error;
- return to IDLE.
REQ-014 SHALL ignore per_ack outside PER_WAIT.
REQ-015 SHALL ignore cpu_re/cpu_we sampled while not in IDLE and set bus_error.
REQ-016 cpu_read_data SHALL hold its value until the next read completes; writes SHALL NOT alter it.
REQ-017 bus_error SHALL be sticky until reset.
REQ-018 Back-to-back requests SHALL be accepted on the first IDLE edge after completion; there is no dead cycle beyond IDLE.

Reset
REQ-019 Asserting rst SHALL immediately force the following, independent of clk:
- state IDLE;
- cpu_mem_busy=0, cpu_read_data=0;
- per_re=0, per_we=0, per_address=0, per_write_data=0;
- bus_error=0, timeout counter=0.
REQ-020 Reset during PER_WAIT SHALL drop the strobes without waiting for per_ack; a late per_ack after reset SHALL be ignored.
REQ-021 RAM contents SHALL NOT be reset.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- RAM write then read: we at 0x4010 with 0xDEADBEEF, then re at 0x4013 -> busy high exactly 1 cycle each; cpu_read_data=0xDEADBEEF 2 edges after the re edge; bus_error=0.
- Peripheral read: re at 0x0100; per_ack after 5 cycles with per_read_data=0x12345678 -> per_re high 5 cycles with per_address=0x0100; cpu_read_data=0x12345678 at the ack edge; busy falls at that edge.
- Peripheral timeout: re at 0x0200, no ack, PER_TIMEOUT=8 -> abort after 8 edges; cpu_read_data=0xFFFFFFFF; bus_error=1.
- Unmapped access: we at 0x0001_0000, then re at 0x8000 -> RAM unchanged; cpu_read_data=0; bus_error=1 until rst.
- Protocol violations: re+we together at 0x4000, then re pulsed during PER_WAIT -> write performed; second request ignored; bus_error=1.
- Reset mid-transaction: rst asserted in PER_WAIT, then per_ack arrives -> per_re=0 and busy=0 immediately; late ack has no effect; state stays IDLE.
